// File: rtl/svm_pkg.sv
// Shared widths, Q-format constants and the saturation helper for the SVM window engine.
package svm_pkg;

    localparam int unsigned SAT_W = 128;
    localparam int unsigned Q_I   = 4;
    localparam int unsigned Q_F   = 28;

    localparam logic [Q_I+Q_F-1:0] ONE = {{(Q_I-1){1'b0}}, 1'b1, {Q_F{1'b0}}};
    localparam logic [Q_I+Q_F-1:0] MAX = {1'b0, {(Q_I+Q_F-1){1'b1}}};
    localparam logic [Q_I+Q_F-1:0] MIN = {1'b1, {(Q_I+Q_F-1){1'b0}}};

    function automatic int unsigned fea_n(input int unsigned fi, input int unsigned ff);
        return fi + ff;
    endfunction

    // Truncated product keeps all integer bits of the full product.
    function automatic int unsigned pw(input int unsigned fi, input int unsigned ff);
        return 2 * fi + ff;
    endfunction

    function automatic int unsigned acc_w(input int unsigned fi, input int unsigned ff,
                                          input int unsigned lanes, input int unsigned blocks);
        return pw(fi, ff) + unsigned'($clog2(lanes)) + unsigned'($clog2(blocks)) + 1;
    endfunction

    // Clamp a sign-extended value into an n-bit two's complement range.
    function automatic logic signed [SAT_W-1:0] sat_to_fea(input logic signed [SAT_W-1:0] v,
                                                           input int unsigned n);
        logic signed [SAT_W-1:0] hi;
        hi = (SAT_W'(1) << (n - 1)) - SAT_W'(1);
        if (v > hi) return hi;
        if (v < ~hi) return ~hi;
        return v;
    endfunction

endpackage

// File: rtl/svm_lane_mult.sv
// One SVM lane: registered signed feature x coefficient product, floor-shifted back to Q format.
module svm_lane_mult
    import svm_pkg::*;
#(
    parameter int unsigned FEA_I = 4,
    parameter int unsigned FEA_F = 28,
    localparam int unsigned FEA_N = fea_n(FEA_I, FEA_F),
    localparam int unsigned PW    = pw(FEA_I, FEA_F)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic signed [FEA_N-1:0] a_i,
    input  logic signed [FEA_N-1:0] b_i,
    output logic signed [PW-1:0]    p_o
);

    logic signed [2*FEA_N-1:0] prod;
    logic signed [PW-1:0]      p_q;

    assign prod = (2*FEA_N)'(a_i) * (2*FEA_N)'(b_i);

    // Arithmetic shift gives floor truncation; the top FEA_F bits are pure sign.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_q <= '0;
        end else if (en_i) begin
            p_q <= PW'(prod >>> FEA_F);
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/svm_window_engine.sv
// Pipelined SVM window scorer: per-beat lane products, lane sum, window accumulate, saturate.
module svm_window_engine
    import svm_pkg::*;
#(
    parameter int unsigned FEA_I  = 4,
    parameter int unsigned FEA_F  = 28,
    parameter int unsigned LANES  = 36,
    parameter int unsigned BLOCKS = 105,
    localparam int unsigned FEA_N = fea_n(FEA_I, FEA_F)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [LANES*FEA_N-1:0] i_fea,
    input  logic [LANES*FEA_N-1:0] i_coef,
    input  logic [FEA_N-1:0]       i_bias,
    input  logic                   i_clear,
    output logic [FEA_N-1:0]       o_score,
    output logic                   o_detect,
    output logic                   o_valid,
    output logic                   o_busy
);

    localparam int unsigned PW    = pw(FEA_I, FEA_F);
    localparam int unsigned SW    = PW + unsigned'($clog2(LANES));
    localparam int unsigned ACC_W = acc_w(FEA_I, FEA_F, LANES, BLOCKS);
    localparam int unsigned SCW   = ACC_W + 1;
    localparam int unsigned CW    = (BLOCKS > 1) ? unsigned'($clog2(BLOCKS)) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(BLOCKS - 1);

    logic                    accept;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [3:0]              vld_q;
    logic                    first0_q, last0_q, first1_q, last1_q, last2_q;
    logic signed [FEA_N-1:0] bias0_q, bias1_q, bias2_q;
    logic signed [PW-1:0]    prod [LANES];
    logic signed [SW-1:0]    sum_d, sum_q;
    logic signed [ACC_W-1:0] acc_d, acc_q;
    logic signed [SCW-1:0]   score;
    logic signed [FEA_N-1:0] sat;
    logic                    fin;
    logic [FEA_N-1:0]        o_score_q;
    logic                    o_detect_q, o_valid_q;

    assign accept = i_valid & ~i_clear;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        svm_lane_mult #(
            .FEA_I(FEA_I),
            .FEA_F(FEA_F)
        ) u_mult (
            .clk  (clk),
            .rst  (rst),
            .en_i (accept),
            .a_i  (i_fea[k*FEA_N +: FEA_N]),
            .b_i  (i_coef[k*FEA_N +: FEA_N]),
            .p_o  (prod[k])
        );
    end

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_valid) begin
            cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < LANES; k++) begin
            sum_d = sum_d + SW'(prod[k]);
        end
    end

    // A first beat reloads the accumulator so windows chain without a clear cycle.
    assign acc_d = first1_q ? ACC_W'(sum_q) : acc_q + ACC_W'(sum_q);
    assign score = SCW'(acc_q) + SCW'(bias2_q);
    assign sat   = FEA_N'(sat_to_fea(SAT_W'(score), FEA_N));
    assign fin   = vld_q[2] & last2_q & ~i_clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q      <= '0;
            vld_q      <= '0;
            first0_q   <= 1'b0;
            last0_q    <= 1'b0;
            first1_q   <= 1'b0;
            last1_q    <= 1'b0;
            last2_q    <= 1'b0;
            bias0_q    <= '0;
            bias1_q    <= '0;
            bias2_q    <= '0;
            sum_q      <= '0;
            acc_q      <= '0;
            o_score_q  <= '0;
            o_detect_q <= 1'b0;
            o_valid_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            vld_q <= i_clear ? 4'b0 : {vld_q[2:0], accept};
            if (accept) begin
                first0_q <= (cnt_q == '0);
                last0_q  <= (cnt_q == LastCnt);
                bias0_q  <= i_bias;
            end
            if (vld_q[0]) begin
                sum_q    <= sum_d;
                first1_q <= first0_q;
                last1_q  <= last0_q;
                bias1_q  <= bias0_q;
            end
            if (vld_q[1] && !i_clear) begin
                acc_q   <= acc_d;
                last2_q <= last1_q;
                bias2_q <= bias1_q;
            end
            o_valid_q <= fin;
            if (fin) begin
                o_score_q  <= sat;
                o_detect_q <= !sat[FEA_N-1] && (sat != '0);
            end
        end
    end

    assign o_score  = o_score_q;
    assign o_detect = o_detect_q;
    assign o_valid  = o_valid_q;
    assign o_busy   = (cnt_q != '0) | (|vld_q);

endmodule

// File: tb/tb_svm_window_engine.sv
// Directed bench for svm_window_engine with a window-level score model and per-cycle compare.
module tb_svm_window_engine;
    import svm_pkg::*;

    localparam int unsigned LANES  = 4;
    localparam int unsigned BLOCKS = 2;
    localparam int unsigned N      = 32;

    logic           clk;
    logic           rst;
    logic           i_valid;
    logic           i_clear;
    logic [LANES*N-1:0] i_fea;
    logic [LANES*N-1:0] i_coef;
    logic [N-1:0]   i_bias;
    logic [N-1:0]   o_score;
    logic           o_detect;
    logic           o_valid;
    logic           o_busy;

    svm_window_engine #(
        .FEA_I (4),
        .FEA_F (28),
        .LANES (LANES),
        .BLOCKS(BLOCKS)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_fea   (i_fea),
        .i_coef  (i_coef),
        .i_bias  (i_bias),
        .i_clear (i_clear),
        .o_score (o_score),
        .o_detect(o_detect),
        .o_valid (o_valid),
        .o_busy  (o_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endfunction

    // Window-level model: sum of floor(fea*coef/2^28) over the window, plus bias, clamped.
    typedef struct {
        int          due;
        logic [31:0] score;
    } exp_t;

    int          cyc = 0;
    int          beat_cnt = 0;
    longint      win_acc = 0;
    int          last_accept = -100;
    exp_t        pend[$];
    logic [31:0] hold_exp = '0;
    int          vcount = 0;
    logic [31:0] last_vscore = '0;
    logic        last_vdetect = 1'b0;

    function automatic longint beat_sum(input logic [LANES*N-1:0] f, input logic [LANES*N-1:0] c);
        longint s;
        longint a;
        longint b;
        s = 0;
        for (int k = 0; k < LANES; k++) begin
            a = longint'($signed(f[k*N +: N]));
            b = longint'($signed(c[k*N +: N]));
            s += (a * b) >>> 28;
        end
        return s;
    endfunction

    function automatic logic [31:0] clamp32(input longint v);
        if (v > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
        if (v < -64'sh8000_0000) return 32'h8000_0000;
        return v[31:0];
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                beat_cnt    = 0;
                win_acc     = 0;
                last_accept = -100;
                pend.delete();
                hold_exp    = '0;
            end else if (i_clear) begin
                beat_cnt    = 0;
                win_acc     = 0;
                last_accept = -100;
                while (pend.size() > 0 && pend[$].due >= cyc) void'(pend.pop_back());
            end else if (i_valid) begin
                win_acc += beat_sum(i_fea, i_coef);
                beat_cnt++;
                last_accept = cyc;
                if (beat_cnt == BLOCKS) begin
                    e.due   = cyc + 3;
                    e.score = clamp32(win_acc + longint'($signed(i_bias)));
                    pend.push_back(e);
                    beat_cnt = 0;
                    win_acc  = 0;
                end
            end
        end
    end

    initial begin
        exp_t e;
        logic exp_v;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("rst_hold_score", o_score, '0);
                chk("rst_hold_valid", 32'(o_valid), 0);
                chk("rst_hold_detect", 32'(o_detect), 0);
                chk("rst_hold_busy", 32'(o_busy), 0);
            end else begin
                exp_v = (pend.size() > 0) && (pend[0].due == cyc);
                chk("o_valid", 32'(o_valid), 32'(exp_v));
                if (exp_v) begin
                    e = pend.pop_front();
                    hold_exp = e.score;
                    chk("o_score", o_score, e.score);
                    chk("o_detect", 32'(o_detect), 32'($signed(e.score) > 0));
                end else begin
                    chk("o_score_hold", o_score, hold_exp);
                    chk("o_detect_hold", 32'(o_detect), 32'($signed(hold_exp) > 0));
                end
                chk("o_busy", 32'(o_busy), 32'((beat_cnt != 0) || (cyc - last_accept <= 3)));
                if (o_valid) begin
                    vcount++;
                    last_vscore  = o_score;
                    last_vdetect = o_detect;
                end
            end
        end
    end

    task automatic beat_vec(input logic v, input logic clr, input logic [LANES*N-1:0] f,
                            input logic [LANES*N-1:0] c, input logic [31:0] b);
        i_valid = v;
        i_clear = clr;
        i_fea   = f;
        i_coef  = c;
        i_bias  = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_clear = 1'b0;
    endtask

    task automatic beat(input logic v, input logic clr, input logic [31:0] f,
                        input logic [31:0] c, input logic [31:0] b);
        beat_vec(v, clr, {LANES{f}}, {LANES{c}}, b);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) beat(1'b0, 1'b0, '0, '0, '0);
    endtask

    localparam logic [31:0] HALF = 32'h0800_0000;
    localparam logic [31:0] TWO  = 32'h2000_0000;

    initial begin
        int v0;
        logic [LANES*N-1:0] fv;
        logic [LANES*N-1:0] cv;
        rst = 1'b0;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_fea = '0;
        i_coef = '0;
        i_bias = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        chk("reset_score", o_score, 32'h0);
        chk("reset_valid", 32'(o_valid), 0);
        chk("reset_busy", 32'(o_busy), 0);

        // Basic sum with explicit latency
        v0 = vcount;
        beat(1'b1, 1'b0, ONE, HALF, '0);
        beat(1'b1, 1'b0, ONE, HALF, '0);
        idle(2);
        chk("lat_early", 32'(o_valid), 0);
        idle(1);
        chk("lat_pulse", 32'(o_valid), 1);
        chk("basic_score", o_score, 32'h4000_0000);
        chk("basic_detect", 32'(o_detect), 1);
        idle(1);
        chk("lat_after", 32'(o_valid), 0);
        idle(3);
        chk("basic_count", 32'(vcount - v0), 1);

        // Saturation both directions
        beat(1'b1, 1'b0, TWO, TWO, '0);
        beat(1'b1, 1'b0, TWO, TWO, '0);
        idle(6);
        chk("sat_pos", last_vscore, 32'h7FFF_FFFF);
        beat(1'b1, 1'b0, TWO, 32'hE000_0000, '0);
        beat(1'b1, 1'b0, TWO, 32'hE000_0000, '0);
        idle(6);
        chk("sat_neg", last_vscore, 32'h8000_0000);
        chk("sat_neg_detect", 32'(last_vdetect), 0);

        // Floor truncation
        beat(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, '0);
        beat(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, '0);
        idle(6);
        chk("floor_score", last_vscore, 32'hFFFF_FFF8);
        chk("floor_detect", 32'(last_vdetect), 0);

        // Chained windows with random gaps
        v0 = vcount;
        for (int w = 0; w < 3; w++) begin
            for (int b = 0; b < 2; b++) begin
                for (int k = 0; k < LANES; k++) begin
                    fv[k*N +: N] = 32'($urandom_range(0, 32'h1FFF_FFFF)) - 32'h1000_0000;
                    cv[k*N +: N] = 32'($urandom_range(0, 32'h1FFF_FFFF)) - 32'h1000_0000;
                end
                beat_vec(1'b1, 1'b0, fv, cv, 32'($urandom_range(0, 32'h0FFF_FFFF)));
                idle(int'($urandom_range(0, 2)));
            end
        end
        idle(8);
        chk("chain_count", 32'(vcount - v0), 3);

        // Bias sampled on the last beat, and zero
        beat(1'b1, 1'b0, '0, '0, 32'h1234_5678);
        beat(1'b1, 1'b0, '0, '0, 32'hFC00_0000);
        idle(6);
        chk("bias_neg", last_vscore, 32'hFC00_0000);
        chk("bias_neg_detect", 32'(last_vdetect), 0);
        beat(1'b1, 1'b0, '0, '0, '0);
        beat(1'b1, 1'b0, '0, '0, '0);
        idle(6);
        chk("zero_score", last_vscore, 32'h0);
        chk("zero_detect", 32'(last_vdetect), 0);

        // Clear after first beat
        v0 = vcount;
        beat(1'b1, 1'b0, 32'h3000_0000, ONE, '0);
        idle(1);
        beat(1'b0, 1'b1, '0, '0, '0);
        beat(1'b1, 1'b0, ONE, HALF, '0);
        beat(1'b1, 1'b0, ONE, HALF, '0);
        idle(6);
        chk("clear_score", last_vscore, 32'h4000_0000);
        chk("clear_count", 32'(vcount - v0), 1);

        // Clear together with valid drops the beat
        v0 = vcount;
        beat(1'b1, 1'b1, 32'h3000_0000, ONE, '0);
        beat(1'b1, 1'b0, ONE, HALF, '0);
        beat(1'b1, 1'b0, ONE, HALF, '0);
        idle(6);
        chk("clrv_score", last_vscore, 32'h4000_0000);
        chk("clrv_count", 32'(vcount - v0), 1);

        // Reset mid-flight
        v0 = vcount;
        beat(1'b1, 1'b0, TWO, TWO, '0);
        beat(1'b1, 1'b0, TWO, TWO, '0);
        idle(1);
        rst = 1'b0;
        #1;
        chk("rst_mid_score", o_score, 32'h0);
        chk("rst_mid_busy", 32'(o_busy), 0);
        idle(2);
        rst = 1'b1;
        idle(6);
        chk("rst_mid_count", 32'(vcount - v0), 0);

        // Recovery after reset
        beat(1'b1, 1'b0, ONE, HALF, '0);
        beat(1'b1, 1'b0, ONE, HALF, '0);
        idle(6);
        chk("recover_score", last_vscore, 32'h4000_0000);
        chk("recover_count", 32'(vcount - v0), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
